// File: rtl/dout_mem_ctrl_if.sv
// Store-request and memory-write bundle for the output data memory controller.
// The master side belongs to the lane requesters; the slave side is the controller.
interface dout_mem_ctrl_if #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 24,
  parameter int CNT_W = 14
);
  logic [N_REQ-1:0]       req;
  logic [N_REQ*WIDTH-1:0] req_addr;
  logic [N_REQ*WIDTH-1:0] req_wd;
  logic [N_REQ-1:0]       gnt;
  logic                   frame_done;
  logic                   mem_we;
  logic [WIDTH-1:0]       mem_addr;
  logic [WIDTH-1:0]       mem_wd;
  logic                   start_io;
  logic                   busy;
  logic [CNT_W-1:0]       wr_count;
  logic                   err_oor;

  modport master (
    output req, req_addr, req_wd, frame_done,
    input  gnt, mem_we, mem_addr, mem_wd, start_io, busy, wr_count, err_oor
  );

  modport slave (
    input  req, req_addr, req_wd, frame_done,
    output gnt, mem_we, mem_addr, mem_wd, start_io, busy, wr_count, err_oor
  );
endinterface

// File: rtl/dout_mem_ctrl.sv
// Round-robin write-port arbiter for the 24-bit output pixel memory: windowed
// address translation, write counting, and a toggle-style dump trigger at frame end.
module dout_mem_ctrl #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 24,
  parameter int BASE  = 24,
  parameter int DEPTH = 10000,
  parameter int CNT_W = 14
) (
  input logic            clk,
  input logic            rst,
  dout_mem_ctrl_if.slave bus
);
  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [WIDTH:0] WIN_LO = (WIDTH+1)'(BASE);
  localparam logic [WIDTH:0] WIN_HI = (WIDTH+1)'(BASE + DEPTH);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DUMP} state_t;

  state_t           state_q, state_d;
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic             mem_we_q, mem_we_d;
  logic [WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [WIDTH-1:0] mem_wd_q, mem_wd_d;
  logic             start_io_q, start_io_d;
  logic [CNT_W-1:0] wr_count_q, wr_count_d;
  logic             err_oor_q, err_oor_d;

  logic [WIDTH-1:0] lane_addr [N_REQ];
  logic [WIDTH-1:0] lane_wd   [N_REQ];
  logic             arb_en;
  logic             gnt_any;
  logic [PTR_W-1:0] gnt_idx;
  logic [N_REQ-1:0] gnt_vec;
  logic [WIDTH-1:0] sel_addr;
  logic             in_win;

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_lane
    assign lane_addr[gi] = bus.req_addr[gi*WIDTH +: WIDTH];
    assign lane_wd[gi]   = bus.req_wd[gi*WIDTH +: WIDTH];
  end

  assign arb_en = (state_q == IDLE) || (state_q == RUN);

  // Scan lanes starting at the pointer; first requester found wins.
  always_comb begin
    int j;
    j       = 0;
    gnt_any = 1'b0;
    gnt_idx = '0;
    for (int i = 0; i < N_REQ; i++) begin
      j = int'(ptr_q) + i;
      if (j >= N_REQ) j = j - N_REQ;
      if (!gnt_any && bus.req[j]) begin
        gnt_any = 1'b1;
        gnt_idx = PTR_W'(j);
      end
    end
    if (!arb_en || rst) gnt_any = 1'b0;
    gnt_vec = gnt_any ? (N_REQ'(1) << gnt_idx) : '0;
  end

  assign sel_addr = lane_addr[gnt_idx];
  assign in_win   = ({1'b0, sel_addr} >= WIN_LO) && ({1'b0, sel_addr} < WIN_HI);

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    mem_we_d   = 1'b0;
    mem_addr_d = mem_addr_q;
    mem_wd_d   = mem_wd_q;
    start_io_d = start_io_q;
    wr_count_d = wr_count_q;
    err_oor_d  = err_oor_q;

    if (gnt_any) begin
      ptr_d = (int'(gnt_idx) == N_REQ - 1) ? '0 : gnt_idx + PTR_W'(1);
      if (in_win) begin
        mem_we_d   = 1'b1;
        mem_addr_d = sel_addr - WIDTH'(BASE);
        mem_wd_d   = lane_wd[gnt_idx];
        if (wr_count_q < CNT_W'(DEPTH)) wr_count_d = wr_count_q + CNT_W'(1);
      end else begin
        err_oor_d = 1'b1;
      end
    end

    case (state_q)
      IDLE:  if ((|bus.req) || bus.frame_done) state_d = RUN;
      RUN:   if (bus.frame_done) state_d = DRAIN;
      DRAIN: begin
        state_d    = DUMP;
        // The memory dumps on either edge, so one inversion means one dump.
        start_io_d = ~start_io_q;
      end
      DUMP: begin
        state_d    = IDLE;
        wr_count_d = '0;
        err_oor_d  = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      mem_we_q   <= 1'b0;
      mem_addr_q <= '0;
      mem_wd_q   <= '0;
      start_io_q <= 1'b0;
      wr_count_q <= '0;
      err_oor_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      mem_we_q   <= mem_we_d;
      mem_addr_q <= mem_addr_d;
      mem_wd_q   <= mem_wd_d;
      start_io_q <= start_io_d;
      wr_count_q <= wr_count_d;
      err_oor_q  <= err_oor_d;
    end
  end

  assign bus.gnt      = gnt_vec;
  assign bus.mem_we   = mem_we_q;
  assign bus.mem_addr = mem_addr_q;
  assign bus.mem_wd   = mem_wd_q;
  assign bus.start_io = start_io_q;
  assign bus.busy     = (state_q == DRAIN) || (state_q == DUMP);
  assign bus.wr_count = wr_count_q;
  assign bus.err_oor  = err_oor_q;
endmodule

// File: tb/tb_dout_mem_ctrl.sv
// Directed bench for dout_mem_ctrl: arbitration order, address window, frame
// end drain/dump sequencing and reset behaviour, all against hand-computed values.
module tb_dout_mem_ctrl;
  logic clk = 1'b0;
  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  dout_mem_ctrl_if #(.N_REQ(4), .WIDTH(24), .CNT_W(14)) bus ();

  dout_mem_ctrl #(
    .N_REQ(4), .WIDTH(24), .BASE(24), .DEPTH(10000), .CNT_W(14)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [23:0] win_a   [5] = '{24'd23, 24'd24, 24'd10023, 24'd10024, 24'hFFFFFF};
  logic        win_we  [5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
  logic [23:0] win_ma  [5] = '{24'd0, 24'd0, 24'd9999, 24'd9999, 24'd9999};
  logic [13:0] win_cnt [5] = '{14'd0, 14'd1, 14'd2, 14'd2, 14'd2};

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      $display("[TB] ok   %s = 0x%0h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_lane(input int i, input logic [23:0] a, input logic [23:0] d);
    bus.req_addr[i*24 +: 24] = a;
    bus.req_wd[i*24 +: 24]   = d;
  endtask

  initial begin
    rst            = 1'b1;
    bus.req        = 4'b0001;
    bus.req_addr   = '0;
    bus.req_wd     = '0;
    bus.frame_done = 1'b0;
    set_lane(0, 24'd24, 24'h123456);
    repeat (2) tick();

    // Reset state; a pending request must not be granted while in reset
    check_eq("rst_gnt", 32'(bus.gnt), 32'h0);
    check_eq("rst_we", 32'(bus.mem_we), 32'h0);
    check_eq("rst_addr", 32'(bus.mem_addr), 32'h0);
    check_eq("rst_wd", 32'(bus.mem_wd), 32'h0);
    check_eq("rst_start", 32'(bus.start_io), 32'h0);
    check_eq("rst_busy", 32'(bus.busy), 32'h0);
    check_eq("rst_cnt", 32'(bus.wr_count), 32'h0);
    check_eq("rst_err", 32'(bus.err_oor), 32'h0);

    // Single store
    rst = 1'b0;
    set_lane(0, 24'd24, 24'hABCDEF);
    bus.req = 4'b0001;
    #1 check_eq("t1_gnt", 32'(bus.gnt), 32'h1);
    tick();
    bus.req = 4'b0000;
    check_eq("t1_we", 32'(bus.mem_we), 32'h1);
    check_eq("t1_addr", 32'(bus.mem_addr), 32'h0);
    check_eq("t1_wd", 32'(bus.mem_wd), 32'hABCDEF);
    check_eq("t1_cnt", 32'(bus.wr_count), 32'h1);

    // Fairness from a fresh pointer
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) set_lane(i, 24'(24 + 10 * i), 24'(32'h100 + i));
    bus.req = 4'b1111;
    for (int c = 0; c < 8; c++) begin
      #1 check_eq($sformatf("rr_gnt%0d", c), 32'(bus.gnt), 32'(1 << (c % 4)));
      tick();
      check_eq($sformatf("rr_we%0d", c), 32'(bus.mem_we), 32'h1);
      check_eq($sformatf("rr_addr%0d", c), 32'(bus.mem_addr), 32'(10 * (c % 4)));
      check_eq($sformatf("rr_wd%0d", c), 32'(bus.mem_wd), 32'(32'h100 + (c % 4)));
      check_eq($sformatf("rr_cnt%0d", c), 32'(bus.wr_count), 32'(c + 1));
    end
    bus.req = 4'b0000;
    #1 check_eq("rr_nogNt", 32'(bus.gnt), 32'h0);
    tick();
    check_eq("rr_idle_we", 32'(bus.mem_we), 32'h0);
    check_eq("rr_hold_addr", 32'(bus.mem_addr), 32'd30);

    // Address window edges, plus an all-ones address to confirm unsigned compare
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.req = 4'b0001;
    for (int k = 0; k < 5; k++) begin
      set_lane(0, win_a[k], 24'(32'h200 + k));
      #1 check_eq($sformatf("win_gnt%0d", k), 32'(bus.gnt), 32'h1);
      tick();
      check_eq($sformatf("win_we%0d", k), 32'(bus.mem_we), 32'(win_we[k]));
      check_eq($sformatf("win_addr%0d", k), 32'(bus.mem_addr), 32'(win_ma[k]));
      check_eq($sformatf("win_cnt%0d", k), 32'(bus.wr_count), 32'(win_cnt[k]));
      check_eq($sformatf("win_err%0d", k), 32'(bus.err_oor), 32'h1);
    end
    check_eq("win_wd_last", 32'(bus.mem_wd), 32'h202);

    // Frame end with a simultaneous last store on lane 2
    bus.req = 4'b0100;
    set_lane(2, 24'd50, 24'h000555);
    bus.frame_done = 1'b1;
    #1 check_eq("fe_gnt", 32'(bus.gnt), 32'h4);
    tick();
    bus.frame_done = 1'b0;
    check_eq("fe_drain_we", 32'(bus.mem_we), 32'h1);
    check_eq("fe_drain_addr", 32'(bus.mem_addr), 32'd26);
    check_eq("fe_drain_wd", 32'(bus.mem_wd), 32'h555);
    check_eq("fe_drain_cnt", 32'(bus.wr_count), 32'd3);
    check_eq("fe_drain_busy", 32'(bus.busy), 32'h1);
    check_eq("fe_drain_start", 32'(bus.start_io), 32'h0);
    #1 check_eq("fe_drain_gnt", 32'(bus.gnt), 32'h0);
    tick();
    check_eq("fe_dump_busy", 32'(bus.busy), 32'h1);
    check_eq("fe_dump_start", 32'(bus.start_io), 32'h1);
    check_eq("fe_dump_we", 32'(bus.mem_we), 32'h0);
    check_eq("fe_dump_cnt", 32'(bus.wr_count), 32'd3);
    #1 check_eq("fe_dump_gnt", 32'(bus.gnt), 32'h0);
    tick();
    check_eq("fe_idle_busy", 32'(bus.busy), 32'h0);
    check_eq("fe_idle_cnt", 32'(bus.wr_count), 32'h0);
    check_eq("fe_idle_err", 32'(bus.err_oor), 32'h0);
    check_eq("fe_idle_start", 32'(bus.start_io), 32'h1);
    #1 check_eq("fe_regrant", 32'(bus.gnt), 32'h4);
    tick();
    check_eq("fe_rewr_we", 32'(bus.mem_we), 32'h1);
    check_eq("fe_rewr_cnt", 32'(bus.wr_count), 32'h1);

    // Second frame: start_io must return to 0, one edge only
    bus.req = 4'b0000;
    bus.frame_done = 1'b1;
    #1 check_eq("f2_gnt", 32'(bus.gnt), 32'h0);
    tick();
    bus.frame_done = 1'b0;
    check_eq("f2_drain_busy", 32'(bus.busy), 32'h1);
    check_eq("f2_drain_start", 32'(bus.start_io), 32'h1);
    check_eq("f2_drain_we", 32'(bus.mem_we), 32'h0);
    tick();
    check_eq("f2_dump_start", 32'(bus.start_io), 32'h0);
    check_eq("f2_dump_busy", 32'(bus.busy), 32'h1);
    tick();
    check_eq("f2_idle_busy", 32'(bus.busy), 32'h0);
    check_eq("f2_idle_start", 32'(bus.start_io), 32'h0);
    check_eq("f2_idle_cnt", 32'(bus.wr_count), 32'h0);
    tick();
    check_eq("f2_hold_start", 32'(bus.start_io), 32'h0);

    // Reset while draining
    bus.req = 4'b0001;
    set_lane(0, 24'd24, 24'h000777);
    #1 check_eq("rd_gnt", 32'(bus.gnt), 32'h1);
    tick();
    check_eq("rd_cnt1", 32'(bus.wr_count), 32'h1);
    bus.frame_done = 1'b1;
    tick();
    bus.frame_done = 1'b0;
    bus.req = 4'b0000;
    check_eq("rd_drain_busy", 32'(bus.busy), 32'h1);
    check_eq("rd_drain_we", 32'(bus.mem_we), 32'h1);
    check_eq("rd_drain_cnt", 32'(bus.wr_count), 32'h2);
    rst = 1'b1;
    tick();
    check_eq("rd_we", 32'(bus.mem_we), 32'h0);
    check_eq("rd_start", 32'(bus.start_io), 32'h0);
    check_eq("rd_busy", 32'(bus.busy), 32'h0);
    check_eq("rd_cnt", 32'(bus.wr_count), 32'h0);
    check_eq("rd_err", 32'(bus.err_oor), 32'h0);
    check_eq("rd_addr", 32'(bus.mem_addr), 32'h0);
    rst = 1'b0;
    tick();
    check_eq("rd_after_start", 32'(bus.start_io), 32'h0);
    check_eq("rd_after_busy", 32'(bus.busy), 32'h0);
    check_eq("rd_after_we", 32'(bus.mem_we), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/dout_mem_ctrl.md
Name: dout_mem_ctrl

Overview:
- Write-side controller for the 24-bit output data memory that holds processed pixels.
- Shares the memory's single write port between N_REQ vector-lane store requesters using round-robin arbitration.
- Translates bus byte addresses to memory word indices, drops out-of-window stores, and counts accepted writes.
- On end of frame, drains the in-flight write, then toggles the memory's dump trigger once.

Parameters:
N_REQ, 4, number of store requesters (lanes)
WIDTH, 24, data and address width
BASE, 24, first bus address mapped to memory index 0
DEPTH, 10000, memory words; valid window is BASE <= addr < BASE+DEPTH
CNT_W, 14, width of write counter (must hold DEPTH)

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous, active-high reset
req  in  N_REQ  per-lane store request; held until granted
req_addr  in  N_REQ*WIDTH  packed bus addresses, lane i at [i*WIDTH +: WIDTH]
req_wd  in  N_REQ*WIDTH  packed store data, same packing
gnt  out  N_REQ  one-hot grant, combinational, same cycle as accepted req
frame_done  in  1  single-cycle pulse: all stores for the frame have been issued
mem_we  out  1  registered write enable to memory
mem_addr  out  WIDTH  registered word index (addr - BASE)
mem_wd  out  WIDTH  registered write data
start_io  out  1  dump trigger; toggles once per completed frame
busy  out  1  high in DRAIN and DUMP
wr_count  out  CNT_W  in-window writes accepted this frame
err_oor  out  1  sticky: an out-of-window store was consumed this frame

Behaviour:
- Reset: state=IDLE; gnt=0, mem_we=0, mem_addr=0, mem_wd=0, start_io=0, busy=0, wr_count=0, err_oor=0; RR pointer=0. Reset mid-frame discards the registered write (mem_we=0 next cycle) without toggling start_io.
- States: IDLE, RUN, DRAIN, DUMP.
  - IDLE -> RUN on any req or frame_done (same-cycle arbitration is allowed from IDLE).
  - RUN -> DRAIN on frame_done.
  - DRAIN -> DUMP after exactly 1 cycle.
  - DUMP -> IDLE after 1 cycle.
- Arbitration (IDLE/RUN only):
  - At most one gnt per cycle, chosen round-robin starting at the RR pointer.
  - After a grant to lane k, the pointer becomes (k+1) mod N_REQ.
  - No req means no grant and the pointer holds.
  - gnt is 0 in DRAIN and DUMP; requesters keep req asserted.
- Frame boundary: frame_done in the same cycle as a req still grants that req (last store of the frame); further grants stop from the next cycle.
- Write path, latency 1: on grant to lane k with a = req_addr[k]:
  - If BASE <= a < BASE+DEPTH: next cycle mem_we=1, mem_addr=a-BASE, mem_wd=req_wd[k]; wr_count increments.
  - Otherwise: the store is consumed (gnt asserted), mem_we=0 next cycle, err_oor set.
  - The comparison is unsigned, in full WIDTH.
  - With no grant, mem_we=0 next cycle; mem_addr and mem_wd hold.
- wr_count saturates at DEPTH.
- DUMP: start_io inverts for the cycle DUMP is entered and holds thereafter. The memory dumps on any edge of start_io, so a toggle (not a pulse) gives exactly one dump.
- IDLE entry from DUMP: wr_count and err_oor clear to 0. The RR pointer is kept.
- busy=1 exactly in DRAIN and DUMP.
- frame_done outside IDLE/RUN is ignored.

Test Plan:
- Reset then single store: req=0001, addr0=24, wd=0xABCDEF -> gnt=0001 same cycle; next cycle mem_we=1, mem_addr=0, mem_wd=0xABCDEF; wr_count=1.
- Fairness: req=1111 held 8 cycles, all in-window -> grants 0001,0010,0100,1000 repeating; 8 writes; wr_count=8.
- Window edges: addresses 23, 24, 10023, 10024 -> only 24 and 10023 write (mem_addr 0 and 9999); err_oor=1; wr_count=2.
- Frame end: frame_done together with req=0100 -> that store is granted and written. Next 2 cycles: gnt=0 with req held, busy=1, start_io 0->1 once. Then IDLE, wr_count=0, err_oor=0, and pending req is granted again.
- Two frames: second frame_done -> start_io 1->0 (exactly one edge per frame).
- Reset during DRAIN: rst asserted -> start_io stays 0, mem_we=0, state IDLE, all counters 0.
